// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared types and constants for the instruction-memory loader
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    FINISH,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/bc_imem_loader_if.sv
// rtl/bc_imem_loader_if.sv - byte stream, memory write and core-control bundle
interface bc_imem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  i_start;
  logic                  i_byte_valid;
  logic [7:0]            i_byte;
  logic                  o_byte_ready;
  logic                  o_wen;
  logic                  o_wdata_valid;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_core_hold;
  logic                  o_prst;
  logic [ADDR_WIDTH-1:0] o_new_pc;
  logic                  o_done;
  logic                  o_overflow;

  modport master (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_wen, o_wdata_valid, o_waddr, o_wdata,
    output o_core_hold, o_prst, o_new_pc, o_done, o_overflow
  );

  modport slave (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_wen, o_wdata_valid, o_waddr, o_wdata,
    input  o_core_hold, o_prst, o_new_pc, o_done, o_overflow
  );

endinterface

// File: rtl/bc_byte_packer.sv
// rtl/bc_byte_packer.sv - assembles four little-endian bytes into a word
import bc_pkg::*;

module bc_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;

  // Bytes enter at the top and shift down, so byte 0 ends in bits [7:0].
  assign o_word       = {i_byte, word_q[31:8]};
  assign o_word_ready = i_accept && !i_clear && (cnt_q == CW'(BYTES_PER_WORD - 1));

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (i_clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (i_accept) begin
      cnt_d  = cnt_q + 1'b1;
      word_d = o_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/bc_imem_loader.sv
// rtl/bc_imem_loader.sv - streams a length-prefixed image into instruction memory
import bc_pkg::*;

module bc_imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_NUM   = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bc_imem_loader_if.master bus
);

  localparam logic [31:0] CAP = 32'(WORD_NUM - BASE_ADDR);

  loader_state_t         state_q, state_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic        byte_ready;
  logic        accept;
  logic        start_load;
  logic [31:0] word;
  logic        word_ready;

  assign byte_ready = (state_q == LEN) || (state_q == DATA);
  assign accept     = bus.i_byte_valid && byte_ready;

  bc_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (start_load),
    .i_accept     (accept),
    .i_byte       (bus.i_byte),
    .o_word       (word),
    .o_word_ready (word_ready)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    wen_d      = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    start_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          start_load = 1'b1;
          state_d    = LEN;
          ovf_d      = 1'b0;
          idx_d      = '0;
        end
      end
      LEN: begin
        if (word_ready) begin
          n_d = word;
          if (word == 32'd0) begin
            state_d = FINISH;
          end else begin
            ovf_d   = (word > CAP);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_ready) begin
          state_d = WRITE;
          // Words past capacity are still consumed, just never written.
          if (idx_q < CAP) begin
            wen_d   = 1'b1;
            waddr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
            wdata_d = DATA_WIDTH'(word);
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 32'd1;
        state_d = (idx_d == n_q) ? FINISH : DATA;
      end
      FINISH:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.o_byte_ready  = byte_ready;
  assign bus.o_wen         = wen_q;
  assign bus.o_wdata_valid = wen_q;
  assign bus.o_waddr       = waddr_q;
  assign bus.o_wdata       = wdata_q;
  assign bus.o_core_hold   = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
  assign bus.o_prst        = (state_q == FINISH);
  assign bus.o_new_pc      = ADDR_WIDTH'(BASE_ADDR);
  assign bus.o_done        = (state_q == DONE);
  assign bus.o_overflow    = ovf_q;

endmodule
